// File: rtl/img_pkg.sv
// Shared definitions for the frame-scan controller: FSM states, scan modes, width helpers.
// Latency: none; the package holds only types, constants and functions.
// Backpressure: not applicable.
package img_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic RASTER = 1'b0;
  localparam logic COLUMN = 1'b1;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the ROM latency down-counter (holds ROM_LAT-1).
  function automatic int lat_cnt_w(input int lat);
    return clog2_min1(lat);
  endfunction

endpackage

// File: rtl/img_coord_gen.sv
// Pixel coordinate generator: x/y counters, scan-order wrap, framing flag decode, ROM address.
// Latency: counters update on the edge after clear/advance; flags and address decode combinationally.
// Backpressure: none; the caller asserts advance only once the current pixel has been accepted.
module img_coord_gen
  import img_pkg::*;
#(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int X_W   = clog2_min1(IMG_W),
  parameter int Y_W   = clog2_min1(IMG_H),
  parameter int A_W   = clog2_min1(IMG_W * IMG_H)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  input  logic           col_mode,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [A_W-1:0] addr,
  output logic           sof,
  output logic           eol,
  output logic           eof
);

  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_last;
  logic           w_y_last;

  assign w_x_last = (r_x == X_MAX);
  assign w_y_last = (r_y == Y_MAX);

  // Coordinate counters: clear restarts the frame, advance steps in the latched scan order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (col_mode == COLUMN) begin
        if (w_y_last) begin
          r_y <= '0;
          r_x <= w_x_last ? '0 : r_x + X_W'(1);
        end else begin
          r_y <= r_y + Y_W'(1);
        end
      end else begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  // Address is always row-major in the ROM, whatever order the frame is walked in.
  assign addr = A_W'(r_y) * A_W'(IMG_W) + A_W'(r_x);
  assign sof  = (r_x == '0) && (r_y == '0);
  assign eof  = w_x_last && w_y_last;
  assign eol  = (col_mode == RASTER) ? w_x_last : w_y_last;

endmodule

// File: rtl/img_scan_ctrl.sv
// Frame-scan controller: one ROM read per pixel, each pixel presented on a valid/ready stream.
// Latency: ROM_LAT+2 cycles per pixel (READ, ROM_LAT x WAIT, PRESENT) plus stall cycles.
// Backpressure: PRESENT holds pixel and sidebands stable until pix_ready; abort drops the frame.
module img_scan_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W   = 4,
  parameter int IMG_H   = 4,
  parameter int PIX_W   = 8,
  parameter int ROM_LAT = 1,
  parameter int X_W     = clog2_min1(IMG_W),
  parameter int Y_W     = clog2_min1(IMG_H),
  parameter int A_W     = clog2_min1(IMG_W * IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             col_mode,
  output logic             rom_en,
  output logic [A_W-1:0]   rom_addr,
  input  logic [PIX_W-1:0] rom_rdata,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             busy,
  output logic             done
);

  localparam int             C_W    = lat_cnt_w(ROM_LAT);
  localparam logic [C_W-1:0] C_LOAD = C_W'(ROM_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [C_W-1:0]   r_cnt;
  logic [C_W-1:0]   w_cnt_nxt;
  logic             w_clear;
  logic             w_advance;
  logic             w_capture;
  logic             r_col_mode;
  logic [PIX_W-1:0] r_pix_data;
  logic [X_W-1:0]   r_pix_x;
  logic [Y_W-1:0]   r_pix_y;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic [A_W-1:0]   w_addr;
  logic             w_sof;
  logic             w_eol;
  logic             w_eof;

  img_coord_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .A_W   (A_W)
  ) u_coord (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .advance  (w_advance),
    .col_mode (r_col_mode),
    .x        (w_x),
    .y        (w_y),
    .addr     (w_addr),
    .sof      (w_sof),
    .eol      (w_eol),
    .eof      (w_eof)
  );

  // FSM state and ROM latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and per-cycle strobes; abort beats a same-cycle handshake, DONE ignores it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = C_LOAD;
        end
      end
      WAIT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = PRESENT;
        end else begin
          w_cnt_nxt = r_cnt - C_W'(1);
        end
      end
      PRESENT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (pix_ready) begin
          if (r_eof) begin
            w_state_nxt = DONE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output pixel registers, loaded once per pixel when the ROM data lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_mode <= RASTER;
      r_pix_data <= '0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_col_mode <= col_mode;
      end
      if (w_capture) begin
        r_pix_data <= rom_rdata;
        r_pix_x    <= w_x;
        r_pix_y    <= w_y;
        r_sof      <= w_sof;
        r_eol      <= w_eol;
        r_eof      <= w_eof;
      end
    end
  end

  assign rom_en    = (r_state == READ);
  assign rom_addr  = w_addr;
  assign pix_valid = (r_state == PRESENT);
  assign pix_data  = r_pix_data;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_sof   = r_sof;
  assign pix_eol   = r_eol;
  assign pix_eof   = r_eof;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_img_scan_ctrl.sv
// Bench for img_scan_ctrl: four instances (4x4 lat1, 4x4 lat3, 5x3 lat1, 1x1 lat2) with ROM models.
// Latency: checks first-valid, per-pixel period, frame length and done timing against hand values.
// Backpressure: exercises held and random pix_ready, abort, mid-frame reset and ignored starts.
module tb_img_scan_ctrl;

  localparam int ND = 4;
  localparam int PW [ND] = '{4, 4, 5, 1};
  localparam int PH [ND] = '{4, 4, 3, 1};
  localparam int PL [ND] = '{1, 3, 1, 2};

  logic clk;
  logic reset;
  logic start   [ND];
  logic abort_i [ND];
  logic colm    [ND];
  logic rdy     [ND];

  wire       en     [ND];
  wire [7:0] addr   [ND];
  wire       valid  [ND];
  wire [7:0] data   [ND];
  wire [7:0] px     [ND];
  wire [7:0] py     [ND];
  wire       sof    [ND];
  wire       eol    [ND];
  wire       eof    [ND];
  wire       busy   [ND];
  wire       done_o [ND];

  int cyc;
  int checks;
  int failures;
  logic [7:0] got [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int W  = PW[g];
    localparam int H  = PH[g];
    localparam int L  = PL[g];
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam int AW = (W * H > 1) ? $clog2(W * H) : 1;

    logic [AW-1:0] w_addr;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_en;
    logic [7:0]    r_pipe [L];

    // ROM model: data = address, L cycles after the strobe; 0xEE marks cycles with no read.
    always @(posedge clk) begin
      r_pipe[0] <= w_en ? 8'(w_addr) : 8'hEE;
      for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
    end

    img_scan_ctrl #(
      .IMG_W   (W),
      .IMG_H   (H),
      .PIX_W   (8),
      .ROM_LAT (L)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start[g]),
      .abort     (abort_i[g]),
      .col_mode  (colm[g]),
      .rom_en    (w_en),
      .rom_addr  (w_addr),
      .rom_rdata (r_pipe[L-1]),
      .pix_valid (valid[g]),
      .pix_ready (rdy[g]),
      .pix_data  (data[g]),
      .pix_x     (w_x),
      .pix_y     (w_y),
      .pix_sof   (sof[g]),
      .pix_eol   (eol[g]),
      .pix_eof   (eof[g]),
      .busy      (busy[g]),
      .done      (done_o[g])
    );

    assign en[g]   = w_en;
    assign addr[g] = 8'(w_addr);
    assign px[g]   = 8'(w_x);
    assign py[g]   = 8'(w_y);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ctrl_w(input int d);
    return {25'd0, en[d], valid[d], busy[d], done_o[d], sof[d], eol[d], eof[d]};
  endfunction

  function automatic logic [31:0] dat_w(input int d);
    return {addr[d], data[d], px[d], py[d]};
  endfunction

  function automatic logic [31:0] beat_w(input int d);
    return {data[d], px[d], py[d], 5'd0, sof[d], eol[d], eof[d]};
  endfunction

  // Expected beat k of a frame, from the scan order directly (not a counter model).
  function automatic logic [31:0] exp_beat(input int d, input logic col, input int k, input int n);
    int w, h, x, y;
    logic fs, fl, fe;
    w  = PW[d];
    h  = PH[d];
    x  = col ? (k / h) : (k % w);
    y  = col ? (k % h) : (k / w);
    fs = (k == 0);
    fe = (k == n - 1);
    fl = col ? (y == h - 1) : (x == w - 1);
    return {8'(y * w + x), 8'(x), 8'(y), 5'd0, fs, fl, fe};
  endfunction

  // rm: 0 = ready held high, 1 = random ready, 2 = random ready plus stray start pulses.
  task automatic run_frame(input int d, input logic col, input int rm, input int n,
                           input int neol, input int ncyc);
    int k, t0, tprev, guard, eols, lat;
    logic seen, early_done;
    lat = PL[d];
    @(negedge clk);
    colm[d]  = col;
    start[d] = 1'b1;
    rdy[d]   = 1'b0;
    @(negedge clk);
    start[d] = 1'b0;
    chk("read_strobe", {busy[d], en[d], addr[d]}, {1'b1, 1'b1, 8'd0});
    t0 = cyc;
    tprev = t0;
    k = 0; guard = 0; eols = 0; seen = 1'b0; early_done = 1'b0;
    while (k < n && guard < 4000) begin
      if (done_o[d]) early_done = 1'b1;
      if (rm == 2) start[d] = ($urandom_range(0, 3) == 0);
      rdy[d] = (rm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (valid[d]) begin
        if (!seen) begin
          seen = 1'b1;
          if (k == 0) chk("first_valid", cyc - t0, 1 + lat);
          else        chk("period", cyc - tprev, lat + 2);
        end
        chk("beat", beat_w(d), exp_beat(d, col, k, n));
        if (rdy[d]) begin
          if (eol[d]) eols++;
          got[k] = data[d];
          tprev = cyc;
          k++;
          seen = 1'b0;
        end
      end
      guard++;
      @(negedge clk);
    end
    rdy[d]   = 1'b0;
    start[d] = (rm == 2);
    chk("beats", k, n);
    chk("no_early_done", early_done, 1'b0);
    chk("eol_count", eols, neol);
    if (ncyc != 0) chk("frame_len", tprev - t0 + 1, ncyc);
    chk("done_pulse", {done_o[d], valid[d]}, {1'b1, 1'b0});
    @(negedge clk);
    start[d] = 1'b0;
    chk("idle_after", {done_o[d], busy[d]}, {1'b0, 1'b0});
  endtask

  typedef struct {
    int   d;
    logic col;
    int   rm;
    int   n;
    int   neol;
    int   ncyc;
    logic colseq;
  } vec_t;

  vec_t vt [9];
  int   exp_col [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, guard, nd, nv;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0; abort_i[d] = 1'b0; colm[d] = 1'b0; rdy[d] = 1'b0;
    end
    exp_col = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    //          d  col   rm  n   eol cyc colseq
    vt[0] = '{0, 1'b0, 0, 16, 4, 48, 1'b0};
    vt[1] = '{0, 1'b1, 0, 16, 4, 48, 1'b1};
    vt[2] = '{1, 1'b0, 1, 16, 4, 0,  1'b0};
    vt[3] = '{1, 1'b1, 1, 16, 4, 0,  1'b1};
    vt[4] = '{1, 1'b0, 0, 16, 4, 80, 1'b0};
    vt[5] = '{2, 1'b0, 2, 15, 3, 0,  1'b0};
    vt[6] = '{2, 1'b1, 0, 15, 5, 45, 1'b0};
    vt[7] = '{3, 1'b0, 0, 1,  1, 4,  1'b0};
    vt[8] = '{3, 1'b1, 2, 1,  1, 0,  1'b0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("reset_ctrl", ctrl_w(d), 32'd0);
      chk("reset_dat", dat_w(d), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_frame(vt[i].d, vt[i].col, vt[i].rm, vt[i].n, vt[i].neol, vt[i].ncyc);
      if (vt[i].colseq) begin
        for (int j = 0; j < 16; j++) chk("col_seq", got[j], 8'(exp_col[j]));
      end
    end

    // Abort in the WAIT cycle of pixel 6 on the 4x4 latency-1 instance.
    @(negedge clk);
    colm[0] = 1'b0; start[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    hs = 0; guard = 0;
    while (hs < 6 && guard < 200) begin
      if (valid[0]) hs++;
      guard++;
      @(negedge clk);
    end
    chk("abort_hs", hs, 6);
    chk("abort_read", {en[0], addr[0]}, {1'b1, 8'd6});
    @(negedge clk);
    chk("abort_wait", {en[0], valid[0], busy[0]}, {1'b0, 1'b0, 1'b1});
    abort_i[0] = 1'b1;
    @(negedge clk);
    abort_i[0] = 1'b0;
    chk("abort_idle", {valid[0], busy[0], done_o[0]}, 3'b000);
    @(negedge clk);
    chk("abort_no_done", {done_o[0], busy[0]}, 2'b00);
    rdy[0] = 1'b0;
    run_frame(0, 1'b0, 0, 16, 4, 48);

    // Reset while pixel 5 stalls in PRESENT on the 4x4 latency-3 instance.
    @(negedge clk);
    colm[1] = 1'b0; start[1] = 1'b1; rdy[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    hs = 0; guard = 0;
    while (hs < 5 && guard < 400) begin
      if (valid[1]) hs++;
      guard++;
      @(negedge clk);
    end
    rdy[1] = 1'b0;
    guard = 0;
    while (!valid[1] && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("stall_hold", beat_w(1), exp_beat(1, 1'b0, 5, 16));
    reset = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    chk("midreset_ctrl", ctrl_w(1), 32'd0);
    chk("midreset_dat", dat_w(1), 32'd0);
    @(negedge clk);
    chk("reset_start_ign", busy[1], 1'b0);
    reset = 1'b0; start[1] = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", ctrl_w(1), 32'd0);

    // Start held high across DONE relaunches the 1x1 frame: R W W P D I per frame.
    @(negedge clk);
    colm[3] = 1'b0; start[3] = 1'b1; rdy[3] = 1'b1;
    nd = 0; nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o[3]) nd++;
      if (valid[3]) nv++;
    end
    start[3] = 1'b0; rdy[3] = 1'b0;
    chk("held_start_done", nd, 2);
    chk("held_start_valid", nv, 2);
    @(negedge clk);
    chk("held_start_end", busy[3], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
